// File: rtl/bioz_freq_sweep_ctrl.sv
// BioZ clock-generator frequency sweep sequencer.
// Steps Fsel through a code range with resync gap, settle and measurement window per step.
module bioz_freq_sweep_ctrl #(
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES  = 4500,
    parameter int unsigned CNT_W         = 24,
    parameter logic [3:0]  DEFAULT_FSEL  = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       continuous,
    input  logic [3:0] fsel_first,
    input  logic [3:0] fsel_last,
    output logic [3:0] Fsel,
    output logic       enable,
    output logic       meas_valid,
    output logic       step_done,
    output logic       sweep_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SETTLE,
        MEAS
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fsel_q, fsel_d;
    logic [3:0]       first_q, first_d;
    logic [3:0]       last_q, last_d;
    logic             cont_q, cont_d;
    logic             enable_q, enable_d;
    logic             meas_q, meas_d;
    logic             step_q, step_d;
    logic             sweep_q, sweep_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fsel_d  = fsel_q;
        first_d = first_q;
        last_d  = last_q;
        cont_d  = cont_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    first_d = fsel_first;
                    last_d  = fsel_last;
                    cont_d  = continuous;
                    fsel_d  = fsel_first;
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = MEAS;
                    cnt_d   = DWELL_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MEAS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (fsel_q != last_q) begin
                    fsel_d  = (fsel_q < last_q) ? fsel_q + 4'd1 : fsel_q - 4'd1;
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else if (cont_q) begin
                    fsel_d  = first_q;
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            fsel_d  = fsel_q;
        end

        // Outputs are registered copies of what the next state implies.
        enable_d = (state_d != GAP);
        meas_d   = (state_d == MEAS);
        busy_d   = (state_d != IDLE);
        step_d   = (state_d == MEAS) && (cnt_d == '0);
        sweep_d  = step_d && (fsel_d == last_q) && !cont_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fsel_q   <= DEFAULT_FSEL;
            first_q  <= '0;
            last_q   <= '0;
            cont_q   <= 1'b0;
            enable_q <= 1'b1;
            meas_q   <= 1'b0;
            step_q   <= 1'b0;
            sweep_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fsel_q   <= fsel_d;
            first_q  <= first_d;
            last_q   <= last_d;
            cont_q   <= cont_d;
            enable_q <= enable_d;
            meas_q   <= meas_d;
            step_q   <= step_d;
            sweep_q  <= sweep_d;
            busy_q   <= busy_d;
        end
    end

    assign Fsel       = fsel_q;
    assign enable     = enable_q;
    assign meas_valid = meas_q;
    assign busy       = busy_q;
    // An abort landing on the final window cycle cancels that cycle's pulses.
    assign step_done  = step_q & ~abort;
    assign sweep_done = sweep_q & ~abort;

endmodule

// File: tb/tb_bioz_freq_sweep_ctrl.sv
// Directed bench for bioz_freq_sweep_ctrl with GAP=2, SETTLE=3, DWELL=5 (10-cycle steps).
module tb_bioz_freq_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       continuous;
    logic [3:0] fsel_first;
    logic [3:0] fsel_last;
    logic [3:0] Fsel;
    logic       enable;
    logic       meas_valid;
    logic       step_done;
    logic       sweep_done;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [3:0] codes [0:7];

    bioz_freq_sweep_ctrl #(
        .GAP_CYCLES   (2),
        .SETTLE_CYCLES(3),
        .DWELL_CYCLES (5),
        .CNT_W        (8),
        .DEFAULT_FSEL (4'b0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .continuous(continuous),
        .fsel_first(fsel_first),
        .fsel_last (fsel_last),
        .Fsel      (Fsel),
        .enable    (enable),
        .meas_valid(meas_valid),
        .step_done (step_done),
        .sweep_done(sweep_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] f);
        chk({tag, "_fsel"}, 8'(Fsel), 8'(f));
        chk({tag, "_en"}, 8'(enable), 8'd1);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_meas"}, 8'(meas_valid), 8'd0);
        chk({tag, "_step"}, 8'(step_done), 8'd0);
        chk({tag, "_sweep"}, 8'(sweep_done), 8'd0);
    endtask

    task automatic do_start(input logic [3:0] f, input logic [3:0] l, input logic c);
        fsel_first = f;
        fsel_last  = l;
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        fsel_first = 4'hf;
        fsel_last  = 4'h7;
        continuous = ~c;
    endtask

    // Checks ncyc cycles from the first cycle after start; codes[] holds per-step Fsel.
    task automatic run(input string tag, input int ncyc, input int nsteps,
                       input bit single, input bit noise);
        for (int k = 0; k < ncyc; k++) begin
            int s = k / 10;
            int p = k % 10;
            chk({tag, "_fsel"}, 8'(Fsel), 8'(codes[s]));
            chk({tag, "_en"}, 8'(enable), 8'(p >= 2));
            chk({tag, "_meas"}, 8'(meas_valid), 8'(p >= 5));
            chk({tag, "_step"}, 8'(step_done), 8'(p == 9));
            chk({tag, "_sweep"}, 8'(sweep_done), 8'(single && s == nsteps - 1 && p == 9));
            chk({tag, "_busy"}, 8'(busy), 8'd1);
            start = noise && (k % 7 == 3);
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        continuous = 1'b0;
        fsel_first = 4'h0;
        fsel_last = 4'h0;
        #1;
        chk_idle("rst_hold", 4'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk_idle("post_rst", 4'h0);
            tick();
        end

        // Single downward sweep 3,2,1
        codes[0] = 4'd3; codes[1] = 4'd2; codes[2] = 4'd1;
        do_start(4'd3, 4'd1, 1'b0);
        run("down", 30, 3, 1'b1, 1'b0);
        chk_idle("down_end", 4'd1);
        tick();
        chk_idle("down_hold", 4'd1);

        // Upward sweep 0,1,2
        codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd2;
        do_start(4'd0, 4'd2, 1'b0);
        run("up", 30, 3, 1'b1, 1'b0);
        chk_idle("up_end", 4'd2);

        // Single-step sweep first==last
        codes[0] = 4'd5;
        do_start(4'd5, 4'd5, 1'b0);
        run("one", 10, 1, 1'b1, 1'b0);
        chk_idle("one_end", 4'd5);

        // Continuous 1,0,1 then abort on third MEAS cycle of step 3
        codes[0] = 4'd1; codes[1] = 4'd0; codes[2] = 4'd1;
        do_start(4'd1, 4'd0, 1'b1);
        run("cont", 27, 3, 1'b0, 1'b0);
        abort = 1'b1;
        chk("cont_ab_meas", 8'(meas_valid), 8'd1);
        chk("cont_ab_step", 8'(step_done), 8'd0);
        tick();
        abort = 1'b0;
        chk_idle("cont_ab_idle", 4'd1);

        // Abort on the final MEAS cycle of a single step
        codes[0] = 4'd2;
        do_start(4'd2, 4'd2, 1'b0);
        run("lastab", 9, 1, 1'b1, 1'b0);
        abort = 1'b1;
        #1;
        chk("lastab_step", 8'(step_done), 8'd0);
        chk("lastab_sweep", 8'(sweep_done), 8'd0);
        tick();
        abort = 1'b0;
        chk_idle("lastab_idle", 4'd2);
        tick();
        chk_idle("lastab_idle2", 4'd2);

        // start and abort together in IDLE
        fsel_first = 4'd9;
        fsel_last = 4'd9;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_idle("sa_idle", 4'd2);
        tick();
        chk_idle("sa_idle2", 4'd2);

        // start pulses mid-sweep are ignored
        codes[0] = 4'd4; codes[1] = 4'd5;
        do_start(4'd4, 4'd5, 1'b0);
        run("noise", 20, 2, 1'b1, 1'b1);
        chk_idle("noise_end", 4'd5);

        // Async reset mid-SETTLE, then a clean sweep
        codes[0] = 4'd3; codes[1] = 4'd2;
        do_start(4'd3, 4'd1, 1'b0);
        run("pre_rst", 4, 3, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_idle("async_rst", 4'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("async_rel", 4'd0);
        codes[0] = 4'd1; codes[1] = 4'd2;
        do_start(4'd1, 4'd2, 1'b0);
        run("clean", 20, 2, 1'b1, 1'b0);
        chk_idle("clean_end", 4'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
